// File: rtl/drec_pkg.sv
// Shared definitions for the recorder SDRAM bridge: FSM state encoding,
// error-flag bit positions and default bus widths.
package drec_pkg;

  localparam int DEFAULT_AW = 24;
  localparam int DEFAULT_DW = 16;

  // Bit positions inside the sticky err_flags vector
  localparam int ERR_WFIFO_OVF   = 0;
  localparam int ERR_RD_OVERRUN  = 1;
  localparam int ERR_ACK_MISSING = 2;
  localparam int ERR_RD_TIMEOUT  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WCMD  = 3'd1,
    ST_RCMD  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RDONE = 3'd4
  } state_e;

endpackage

// File: rtl/drec_sync_fifo.sv
// Small synchronous FIFO used as the bridge's write buffer.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// a push while full and a pop while empty are both ignored.
module drec_sync_fifo
  import drec_pkg::*;
#(
  parameter int WIDTH = DEFAULT_AW + DEFAULT_DW,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wrPtr_q;
  logic [PW:0]      rdPtr_q;
  logic             pushOk;
  logic             popOk;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PW] != rdPtr_q[PW]) &&
                   (wrPtr_q[PW-1:0] == rdPtr_q[PW-1:0]);
  assign data_o  = mem_q[rdPtr_q[PW-1:0]];
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;

  // Pointer update; both pointers wrap naturally modulo the depth
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (pushOk) wrPtr_q <= wrPtr_q + 1'b1;
      if (popOk)  rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  // Storage array needs no reset; empty pointers hide stale contents
  always_ff @(posedge clk_i) begin
    if (pushOk) mem_q[wrPtr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/drec_sdram_bridge.sv
// Bridge between the recorder controller's request pulses and a single
// SDRAM-core command port. Writes are buffered, reads use a one-entry slot
// and take priority. Optional read timeout is enabled by defining
// DREC_BRIDGE_TIMEOUT_EN; without it RWAIT waits forever and err_flags[3]
// stays 0.
module drec_sdram_bridge
  import drec_pkg::*;
#(
  parameter int AW          = DEFAULT_AW,
  parameter int DW          = DEFAULT_DW,
  parameter int WFIFO_DEPTH = 4,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic          wr_enable_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_enable_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_data_rdy_o,
  input  logic          rd_data_ack_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wr_o,
  output logic          mem_rd_o,
  input  logic          mem_busy_i,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_rd_valid_i,
  output logic [3:0]    err_flags_o
);

  state_e state_q, state_d;

  logic          fifoFull;
  logic          fifoEmpty;
  logic          fifoPop;
  logic [AW-1:0] fifoHeadAddr;
  logic [DW-1:0] fifoHeadData;

  logic          slotValid_q;
  logic [AW-1:0] slotAddr_q;

  logic          captured_q;
  logic          rdTimeout;
  logic          rdCapture;
  logic [DW-1:0] rdData_q;
  logic          rdRdy_q;

  logic          memWr_q, memWr_d;
  logic          memRd_q, memRd_d;
  logic [AW-1:0] memAddr_q, memAddr_d;
  logic [DW-1:0] memWdata_q, memWdata_d;
  logic          memAccept;

  logic [3:0]    err_q;

  assign memAccept = (memWr_q || memRd_q) && !mem_busy_i;
  assign fifoPop   = (state_q == ST_WCMD) && memAccept;

  drec_sync_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (WFIFO_DEPTH)
  ) uWriteFifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_enable_i),
    .data_i  ({wr_addr_i, wr_data_i}),
    .pop_i   (fifoPop),
    .data_o  ({fifoHeadAddr, fifoHeadData}),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

`ifdef DREC_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT) + 1;
  logic [TW-1:0] tmoCnt_q;

  assign rdTimeout = (state_q == ST_RWAIT) && !captured_q && !mem_rd_valid_i &&
                     (tmoCnt_q == TW'(RD_TIMEOUT - 1));

  // Count RWAIT cycles spent without read data; restarts on every new read
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmoCnt_q <= '0;
    end else if (state_q != ST_RWAIT) begin
      tmoCnt_q <= '0;
    end else if (!captured_q && (tmoCnt_q != TW'(RD_TIMEOUT - 1))) begin
      tmoCnt_q <= tmoCnt_q + TW'(1);
    end
  end
`else
  assign rdTimeout = 1'b0;
`endif

  assign rdCapture = (state_q == ST_RWAIT) && !captured_q &&
                     (mem_rd_valid_i || rdTimeout);

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: pending read beats buffered writes; RWAIT ends once rdy has pulsed
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (slotValid_q)     state_d = ST_RCMD;
        else if (!fifoEmpty) state_d = ST_WCMD;
      end
      ST_WCMD:  if (memAccept) state_d = ST_IDLE;
      ST_RCMD:  if (memAccept) state_d = ST_RWAIT;
      ST_RWAIT: if (captured_q && rdRdy_q) state_d = ST_RDONE;
      ST_RDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command outputs: loaded when leaving IDLE, held while busy, cleared on accept
  always_comb begin
    memWr_d    = memWr_q;
    memRd_d    = memRd_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (state_q)
      ST_IDLE: begin
        if (slotValid_q) begin
          memRd_d   = 1'b1;
          memAddr_d = slotAddr_q;
        end else if (!fifoEmpty) begin
          memWr_d    = 1'b1;
          memAddr_d  = fifoHeadAddr;
          memWdata_d = fifoHeadData;
        end
      end
      ST_WCMD, ST_RCMD: begin
        if (!mem_busy_i) begin
          memWr_d = 1'b0;
          memRd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Command register bank driving the SDRAM core
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      memWr_q    <= 1'b0;
      memRd_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      memWr_q    <= memWr_d;
      memRd_q    <= memRd_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  // Read slot: occupied from request until the RDONE handshake frees it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slotValid_q <= 1'b0;
      slotAddr_q  <= '0;
    end else if (state_q == ST_RDONE) begin
      slotValid_q <= 1'b0;
    end else if (rd_enable_i && !slotValid_q) begin
      slotValid_q <= 1'b1;
      slotAddr_q  <= rd_addr_i;
    end
  end

  // Read return: capture data (zero on timeout), then pulse rdy one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      captured_q <= 1'b0;
      rdData_q   <= '0;
      rdRdy_q    <= 1'b0;
    end else begin
      if (rdCapture) begin
        captured_q <= 1'b1;
        rdData_q   <= mem_rd_valid_i ? mem_rdata_i : '0;
      end else if (state_q == ST_RDONE) begin
        captured_q <= 1'b0;
      end
      rdRdy_q <= (state_q == ST_RWAIT) && captured_q && !rdRdy_q;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      if (wr_enable_i && fifoFull)                  err_q[ERR_WFIFO_OVF]   <= 1'b1;
      if (rd_enable_i && slotValid_q)               err_q[ERR_RD_OVERRUN]  <= 1'b1;
      if ((state_q == ST_RDONE) && !rd_data_ack_i)  err_q[ERR_ACK_MISSING] <= 1'b1;
      if (rdTimeout)                                err_q[ERR_RD_TIMEOUT]  <= 1'b1;
    end
  end

  assign mem_wr_o      = memWr_q;
  assign mem_rd_o      = memRd_q;
  assign mem_addr_o    = memAddr_q;
  assign mem_wdata_o   = memWdata_q;
  assign rd_data_o     = rdData_q;
  assign rd_data_rdy_o = rdRdy_q;
  assign err_flags_o   = err_q;

endmodule

// File: tb/tb_drec_sdram_bridge.sv
// Self-checking bench for drec_sdram_bridge. A queue-based scoreboard holds
// the expected SDRAM commands and read returns; a small core model answers
// reads and an ack model acknowledges rdy pulses. Timeout checks are built
// only when DREC_BRIDGE_TIMEOUT_EN is defined.
module tb_drec_sdram_bridge;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int RD_TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rstN;
  logic [DW-1:0] wrData;
  logic [AW-1:0] wrAddr;
  logic          wrEnable;
  logic [AW-1:0] rdAddr;
  logic          rdEnable;
  logic [DW-1:0] rdData;
  logic          rdRdy;
  logic          rdAck;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic          memWr;
  logic          memRd;
  logic          memBusy;
  logic [DW-1:0] memRdata;
  logic          memRdValid;
  logic [3:0]    errFlags;

  typedef struct {
    logic          isRd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic          isRd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    expErr;
  } vec_t;

  cmd_t          cmdQ[$];
  logic [DW-1:0] rdQ[$];
  vec_t          vecs[6];

  int            total = 0;
  int            bad = 0;
  bit            respEnable = 1'b1;
  bit            ackEnable = 1'b1;
  int            rdLatency = 3;
  logic [DW-1:0] respData = '0;

  always #5 clk = ~clk;

  drec_sdram_bridge #(
    .AW          (AW),
    .DW          (DW),
    .WFIFO_DEPTH (4),
    .RD_TIMEOUT  (RD_TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .wr_data_i      (wrData),
    .wr_addr_i      (wrAddr),
    .wr_enable_i    (wrEnable),
    .rd_addr_i      (rdAddr),
    .rd_enable_i    (rdEnable),
    .rd_data_o      (rdData),
    .rd_data_rdy_o  (rdRdy),
    .rd_data_ack_i  (rdAck),
    .mem_addr_o     (memAddr),
    .mem_wdata_o    (memWdata),
    .mem_wr_o       (memWr),
    .mem_rd_o       (memRd),
    .mem_busy_i     (memBusy),
    .mem_rdata_i    (memRdata),
    .mem_rd_valid_i (memRdValid),
    .err_flags_o    (errFlags)
  );

  // One comparison: counts it, reports mismatches with both values
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one request cycle starting just after a rising edge
  task automatic applyStimulus(input bit doWr, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input bit doRd,
                               input logic [AW-1:0] ra);
    @(posedge clk); #1;
    wrEnable = doWr; wrAddr = wa; wrData = wd;
    rdEnable = doRd; rdAddr = ra;
    @(posedge clk); #1;
    wrEnable = 1'b0;
    rdEnable = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard is empty, then let RDONE retire
  task automatic waitDrain(input int budget, input string name);
    int n = 0;
    while (((cmdQ.size() + rdQ.size()) != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, cmdQ.size() + rdQ.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rstN = 1'b0;
    wrEnable = 1'b0; rdEnable = 1'b0; memBusy = 1'b0;
    cmdQ.delete();
    rdQ.delete();
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  // Scoreboard monitor: every accepted command and every rdy pulse is popped
  initial forever begin
    cmd_t exp;
    @(negedge clk);
    if (rstN) begin
      if ((memWr || memRd) && !memBusy) begin
        if (cmdQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_cmd: got wr=%0b rd=%0b addr=0x%0h, required no command",
                   memWr, memRd, memAddr);
        end else begin
          exp = cmdQ.pop_front();
          checkOutput("cmd_rd", memRd, exp.isRd);
          checkOutput("cmd_wr", memWr, !exp.isRd);
          checkOutput("cmd_addr", memAddr, exp.addr);
          if (!exp.isRd) checkOutput("cmd_wdata", memWdata, exp.data);
        end
      end
      if (rdRdy) begin
        if (rdQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_rdy: got rd_data=0x%0h, required no rdy pulse", rdData);
        end else begin
          checkOutput("rd_data", rdData, rdQ.pop_front());
        end
      end
    end
  end

  // SDRAM core model: returns respData a few cycles after a read is accepted
  initial begin
    memRdValid = 1'b0;
    memRdata = '0;
    forever begin
      @(negedge clk);
      if (rstN && memRd && !memBusy && respEnable) begin
        repeat (rdLatency) @(posedge clk);
        #1;
        memRdValid = 1'b1;
        memRdata = respData;
        @(posedge clk); #1;
        memRdValid = 1'b0;
      end
    end
  end

  // Controller ack model: acknowledges exactly one cycle after rdy
  initial begin
    rdAck = 1'b0;
    forever begin
      @(negedge clk);
      if (rstN && rdRdy && ackEnable) begin
        @(posedge clk); #1 rdAck = 1'b1;
        @(posedge clk); #1 rdAck = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rstN = 1'b0;
    wrData = '0; wrAddr = '0; wrEnable = 1'b0;
    rdAddr = '0; rdEnable = 1'b0; memBusy = 1'b0;

    vecs[0] = '{isRd: 1'b0, addr: 24'h000010, data: 16'hA5A5, expErr: 4'h0};
    vecs[1] = '{isRd: 1'b1, addr: 24'h000020, data: 16'h1234, expErr: 4'h0};
    vecs[2] = '{isRd: 1'b0, addr: 24'hFFFFFF, data: 16'hFFFF, expErr: 4'h0};
    vecs[3] = '{isRd: 1'b0, addr: 24'h000000, data: 16'h0000, expErr: 4'h0};
    vecs[4] = '{isRd: 1'b1, addr: 24'hABCDEF, data: 16'hBEEF, expErr: 4'h0};
    vecs[5] = '{isRd: 1'b1, addr: 24'hFFFFFF, data: 16'h0000, expErr: 4'h0};

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    checkOutput("rst_err", errFlags, 4'h0);
    checkOutput("rst_cmd", {memWr, memRd}, 2'b00);
    checkOutput("rst_rdy", rdRdy, 1'b0);
    checkOutput("rst_addr", memAddr, 24'h0);
    checkOutput("rst_rdata", rdData, 16'h0);
    doReset();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].isRd) begin
        respData = vecs[i].data;
        cmdQ.push_back('{isRd: 1'b1, addr: vecs[i].addr, data: '0});
        rdQ.push_back(vecs[i].data);
        applyStimulus(1'b0, '0, '0, 1'b1, vecs[i].addr);
      end else begin
        cmdQ.push_back('{isRd: 1'b0, addr: vecs[i].addr, data: vecs[i].data});
        applyStimulus(1'b1, vecs[i].addr, vecs[i].data, 1'b0, '0);
      end
      waitDrain(40, $sformatf("vec%0d_drain", i));
      checkOutput($sformatf("vec%0d_err", i), errFlags, vecs[i].expErr);
      if (vecs[i].isRd) checkOutput($sformatf("vec%0d_rd_hold", i), rdData, vecs[i].data);
    end

    // Read latency: command two edges after request, rdy two edges after valid
    respData = 16'h4321;
    cmdQ.push_back('{isRd: 1'b1, addr: 24'h000123, data: '0});
    rdQ.push_back(16'h4321);
    @(posedge clk); #1;
    rdEnable = 1'b1; rdAddr = 24'h000123;
    @(posedge clk); #1;
    rdEnable = 1'b0;
    @(negedge clk);
    checkOutput("lat_rd_early", memRd, 1'b0);
    @(negedge clk);
    checkOutput("lat_rd_cmd", memRd, 1'b1);
    n = 0;
    while (!memRdValid && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("lat_valid_seen", memRdValid, 1'b1);
    @(negedge clk);
    checkOutput("lat_rdy_early", rdRdy, 1'b0);
    @(negedge clk);
    checkOutput("lat_rdy", rdRdy, 1'b1);
    waitDrain(40, "lat_drain");
    checkOutput("lat_err", errFlags, 4'h0);

    // Overflow: core busy, five writes into a four-entry buffer
    doReset();
    memBusy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) cmdQ.push_back('{isRd: 1'b0, addr: 24'h000100 + k, data: 16'h1000 + k[15:0]});
      applyStimulus(1'b1, 24'h000100 + k, 16'h1000 + k[15:0], 1'b0, '0);
    end
    @(negedge clk);
    checkOutput("ovf_err", errFlags, 4'h1);
    checkOutput("ovf_hold_wr", memWr, 1'b1);
    checkOutput("ovf_hold_addr", memAddr, 24'h000100);
    @(posedge clk); #1;
    memBusy = 1'b0;
    waitDrain(60, "ovf_drain");
    checkOutput("ovf_err_sticky", errFlags, 4'h1);

    // Priority: simultaneous write and read, read command must go first
    doReset();
    respData = 16'h5A5A;
    cmdQ.push_back('{isRd: 1'b1, addr: 24'h000040, data: '0});
    cmdQ.push_back('{isRd: 1'b0, addr: 24'h000030, data: 16'hC3C3});
    rdQ.push_back(16'h5A5A);
    applyStimulus(1'b1, 24'h000030, 16'hC3C3, 1'b1, 24'h000040);
    waitDrain(60, "prio_drain");
    checkOutput("prio_err", errFlags, 4'h0);

    // Overrun during RWAIT, then a withheld ack
    doReset();
    rdLatency = 8;
    ackEnable = 1'b0;
    respData = 16'h7777;
    cmdQ.push_back('{isRd: 1'b1, addr: 24'h000050, data: '0});
    rdQ.push_back(16'h7777);
    applyStimulus(1'b0, '0, '0, 1'b1, 24'h000050);
    repeat (3) @(posedge clk);
    applyStimulus(1'b0, '0, '0, 1'b1, 24'h000060);
    @(negedge clk);
    checkOutput("ovr_err", errFlags, 4'h2);
    waitDrain(60, "ovr_drain");
    checkOutput("ack_err", errFlags, 4'h6);
    ackEnable = 1'b1;
    rdLatency = 3;
    doReset();
    @(negedge clk);
    checkOutput("ack_rst_clear", errFlags, 4'h0);

`ifdef DREC_BRIDGE_TIMEOUT_EN
    // Timeout: core never answers
    respEnable = 1'b0;
    cmdQ.push_back('{isRd: 1'b1, addr: 24'h000070, data: '0});
    rdQ.push_back(16'h0000);
    applyStimulus(1'b0, '0, '0, 1'b1, 24'h000070);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdRdy && (n < 200));
    checkOutput("tmo_latency", n, 68);
    waitDrain(20, "tmo_drain");
    checkOutput("tmo_err", errFlags, 4'h8);
    respEnable = 1'b1;
    doReset();
    @(negedge clk);
    checkOutput("tmo_rst_err", errFlags, 4'h0);
    checkOutput("tmo_rst_rdata", rdData, 16'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
